// File: rtl/bcd_display_pkg.sv
// Shared constants for the 4-digit BCD display multiplexer.
//   - Seven-segment patterns, active high, bit 6 = a ... bit 0 = g.
//   - Digit index values used by the scan counter.
//   - Helper that flags a nibble outside the BCD range.
package bcd_display_pkg;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_DASH  = 7'b0000001;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam logic [1:0] DIG_UNITS     = 2'd0;
    localparam logic [1:0] DIG_TENS      = 2'd1;
    localparam logic [1:0] DIG_HUNDREDS  = 2'd2;
    localparam logic [1:0] DIG_THOUSANDS = 2'd3;

    // All digit enables released (active-low anodes).
    localparam logic [3:0] AN_OFF = 4'b1111;

    function automatic logic nib_bad(input logic [3:0] nib);
        return nib > 4'd9;
    endfunction

endpackage

// File: rtl/bcd_display_mux_4_bcd_to_7seg.sv
// bcd_to_7seg: combinational nibble to seven-segment decoder.
//   nib_i [3:0] : digit value
//   seg_o [6:0] : active-high segments (a..g); values 10..15 give a dash
module bcd_to_7seg
    import bcd_display_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (nib_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_mux_4.sv
// bcd_display_mux_4: time-multiplexed driver for a 4-digit seven-segment
// display showing a 3-digit BCD adder sum plus its carry as thousands "1".
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   load    : capture strobe for bcd_in / cout_in
//   bcd_in  : {hundreds, tens, units}, one BCD nibble each
//   cout_in : carry-out, displayed as thousands digit 1 (or 0)
//   seg     : active-high segments, seg[6]=a ... seg[0]=g (registered)
//   an      : active-low digit enables, an[0]=units ... an[3]=thousands (registered)
//   err     : last captured value had a nibble above 9 (registered)
// A prescaler divides clk into ticks of REFRESH_DIV cycles; each tick
// registers one digit slot and advances the scan units->tens->hundreds->thousands.
module bcd_display_mux_4
    import bcd_display_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [11:0] bcd_in,
    input  logic        cout_in,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        err
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

    logic [11:0]   hold_q, hold_d;
    logic          cout_q, cout_d;
    logic          err_q, err_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q, idx_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;

    logic          tick;
    logic [3:0]    cur_nib;
    logic [6:0]    dec_seg;
    logic          blank_th, blank_hu, blank_te;
    logic          cur_blank;

    assign tick = (presc_q == PRESC_LAST);

    // Leading-zero blanking cascades down from thousands; a non-BCD
    // nibble compares unequal to zero and so stops the cascade.
    assign blank_th = BLANK_LZ && !cout_q;
    assign blank_hu = blank_th && (hold_q[11:8] == 4'd0);
    assign blank_te = blank_hu && (hold_q[7:4] == 4'd0);

    always_comb begin
        cur_nib   = hold_q[3:0];
        cur_blank = 1'b0;
        case (idx_q)
            DIG_UNITS: begin
                cur_nib   = hold_q[3:0];
                cur_blank = 1'b0;
            end
            DIG_TENS: begin
                cur_nib   = hold_q[7:4];
                cur_blank = blank_te;
            end
            DIG_HUNDREDS: begin
                cur_nib   = hold_q[11:8];
                cur_blank = blank_hu;
            end
            DIG_THOUSANDS: begin
                cur_nib   = {3'b000, cout_q};
                cur_blank = blank_th;
            end
            default: begin
                cur_nib   = hold_q[3:0];
                cur_blank = 1'b0;
            end
        endcase
    end

    bcd_to_7seg u_dec (
        .nib_i (cur_nib),
        .seg_o (dec_seg)
    );

    // The slot is computed from the pre-load hold value, so a load on a
    // tick cycle only becomes visible from the following tick.
    always_comb begin
        hold_d  = hold_q;
        cout_d  = cout_q;
        err_d   = err_q;
        presc_d = presc_q + PW'(1);
        idx_d   = idx_q;
        seg_d   = seg_q;
        an_d    = an_q;
        if (load) begin
            hold_d = bcd_in;
            cout_d = cout_in;
            err_d  = nib_bad(bcd_in[3:0]) | nib_bad(bcd_in[7:4]) | nib_bad(bcd_in[11:8]);
        end
        if (tick) begin
            presc_d = '0;
            idx_d   = idx_q + 2'd1;
            if (cur_blank) begin
                seg_d = SEG_BLANK;
                an_d  = AN_OFF;
            end else begin
                seg_d = dec_seg;
                an_d  = ~(4'b0001 << idx_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q  <= '0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
            presc_q <= '0;
            idx_q   <= DIG_UNITS;
            seg_q   <= SEG_BLANK;
            an_q    <= AN_OFF;
        end else begin
            hold_q  <= hold_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign err = err_q;

endmodule

// File: tb/tb_bcd_display_mux_4.sv
// Directed testbench for bcd_display_mux_4 with REFRESH_DIV=4.
// Two instances share the stimulus: one with leading-zero blanking, one without.
module tb_bcd_display_mux_4;

    localparam int DIV = 4;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [11:0] bcd_in;
    logic        cout_in;
    logic [6:0]  seg, seg_nb;
    logic [3:0]  an, an_nb;
    logic        err, err_nb;

    int n_total;
    int n_pass;
    int cnt;   // rising edges since reset release

    bcd_display_mux_4 #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b1)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .bcd_in  (bcd_in),
        .cout_in (cout_in),
        .seg     (seg),
        .an      (an),
        .err     (err)
    );

    bcd_display_mux_4 #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b0)) dut_nb (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .bcd_in  (bcd_in),
        .cout_in (cout_in),
        .seg     (seg_nb),
        .an      (an_nb),
        .err     (err_nb)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        if (obs !== exp)
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        else
            n_pass++;
    endtask

    // One rising edge, then sample 1 time unit later.
    task automatic cyc();
        @(posedge clk);
        cnt++;
        #1;
    endtask

    task automatic release_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cnt   = 0;
    endtask

    // Advance to the next tick edge that registers digit slot d.
    task automatic run_to_slot(input int d);
        int guard;
        guard = 0;
        do begin
            cyc();
            guard++;
        end while (!((cnt % DIV == 0) && (cnt > 0) && (((cnt / DIV) - 1) % 4 == d)) && guard < 64);
        if (guard >= 64)
            check("slot_timeout", 16'(guard), 16'd0);
    endtask

    task automatic do_load(input logic [11:0] v, input logic c);
        load    = 1'b1;
        bcd_in  = v;
        cout_in = c;
        cyc();
        load    = 1'b0;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        cnt     = 0;
        rst_n   = 1'b0;
        load    = 1'b0;
        bcd_in  = '0;
        cout_in = 1'b0;

        // Reset state and first tick
        #12;
        check("rst_an",  16'(an),  16'b1111);
        check("rst_seg", 16'(seg), 16'b0000000);
        check("rst_err", 16'(err), 16'd0);
        release_reset();
        repeat (3) cyc();
        check("pre_tick", 16'({an, seg}), 16'b1111_0000000);
        cyc();
        check("tick1_units", 16'({an, seg}), 16'b1110_1111110);

        // 1000 = 0x000 with carry, nothing blanked
        do_load(12'h000, 1'b1);
        check("c1000_err", 16'(err), 16'd0);
        run_to_slot(0); check("c1000_u", 16'({an, seg}), 16'b1110_1111110);
        run_to_slot(1); check("c1000_t", 16'({an, seg}), 16'b1101_1111110);
        run_to_slot(2); check("c1000_h", 16'({an, seg}), 16'b1011_1111110);
        run_to_slot(3); check("c1000_k", 16'({an, seg}), 16'b0111_0110000);

        // 027: blanking on vs off
        do_load(12'h027, 1'b0);
        run_to_slot(0);
        check("b027_u",    16'({an, seg}),       16'b1110_1110000);
        check("b027_u_nb", 16'({an_nb, seg_nb}), 16'b1110_1110000);
        run_to_slot(1); check("b027_t", 16'({an, seg}), 16'b1101_1101101);
        run_to_slot(2);
        check("b027_h",    16'({an, seg}),       16'b1111_0000000);
        check("b027_h_nb", 16'({an_nb, seg_nb}), 16'b1011_1111110);
        run_to_slot(3);
        check("b027_k",    16'({an, seg}),       16'b1111_0000000);
        check("b027_k_nb", 16'({an_nb, seg_nb}), 16'b0111_1111110);

        // 0A5: non-BCD tens nibble
        do_load(12'h0A5, 1'b0);
        check("a05_err",    16'(err),    16'd1);
        check("a05_err_nb", 16'(err_nb), 16'd1);
        run_to_slot(0); check("a05_u", 16'({an, seg}), 16'b1110_1011011);
        run_to_slot(1); check("a05_t", 16'({an, seg}), 16'b1101_0000001);
        run_to_slot(2); check("a05_h", 16'({an, seg}), 16'b1111_0000000);
        do_load(12'h005, 1'b0);
        check("a05_err_clr", 16'(err), 16'd0);

        // Load coinciding with a tick uses the old hold value
        do_load(12'h111, 1'b0);
        run_to_slot(3);
        repeat (DIV - 1) cyc();
        do_load(12'h999, 1'b0);
        check("coinc_old", 16'({an, seg}), 16'b1110_0110000);
        run_to_slot(1);
        check("coinc_new", 16'({an, seg}), 16'b1101_1111011);

        // Asynchronous reset mid-slot with idx=2
        cyc();
        rst_n = 1'b0;
        #2;
        check("arst_an",  16'(an),  16'b1111);
        check("arst_seg", 16'(seg), 16'b0000000);
        check("arst_err", 16'(err), 16'd0);
        release_reset();
        repeat (DIV - 1) cyc();
        check("arst_pre", 16'({an, seg}), 16'b1111_0000000);
        cyc();
        check("arst_units", 16'({an, seg}), 16'b1110_1111110);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
